ewrapper_rx_align_ctrl: RTL and testbench
=========================================

EWRAPPER_RX_ALIGN_CTRL -- requirements
Module: ewrapper_rx_align_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 8'h3C, expected training byte on frame lane.
REQ-002 SHALL have parameter MATCH_NEEDED, default 16, consecutive matching words to declare lock (range 1..255).
REQ-003 SHALL have parameter LOSS_THRESH, default 4, consecutive mismatching words in LOCKED to declare loss (range 1..15).
REQ-004 SHALL have parameter SLIP_WAIT, default 4, word strobes ignored after each slip (range 1..15).
REQ-005 SHALL have port rxi_lclk  in  1  fast link clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port enable  in  1  level; high runs alignment, low holds block in IDLE.
REQ-008 SHALL have port word_valid  in  1  one-cycle strobe, at most one per 4 cycles, marking a new deserialized word.
REQ-009 SHALL have port frame_byte  in  8  deserialized frame-lane byte, valid with word_valid.
REQ-010 SHALL have port bitslip  out  1  one-cycle pulse requesting a one-bit slip of the deserializer.
REQ-011 SHALL have port slip_cnt  out  3  slips issued since last search start, mod 8.
REQ-012 SHALL have port locked  out  1  high while in LOCKED.
REQ-013 SHALL have port align_fail  out  1  sticky; set after 8 slips without lock.
REQ-014 SHALL have port err_cnt  out  16  saturating count of mismatching words seen while LOCKED.

Function
REQ-015 SHALL implement states IDLE, CHECK, SLIP, WAIT, LOCKED; all outputs registered.
REQ-016 IDLE: enable high -> CHECK next cycle, match count and wait count cleared.
REQ-017 CHECK: word_valid with frame_byte==PATTERN increments match count; reaching MATCH_NEEDED -> LOCKED next cycle, locked high that cycle.
REQ-018 CHECK: word_valid with mismatch clears match count -> SLIP next cycle.
REQ-019 SLIP: bitslip high exactly one cycle, slip_cnt increments mod 8, -> WAIT.
REQ-020 SLIP: when slip_cnt wraps 7->0, align_fail SHALL set on the same edge; search continues.
REQ-021 WAIT: counts word_valid strobes, compares nothing; after SLIP_WAIT strobes -> CHECK.
REQ-022 LOCKED: mismatch increments loss count and err_cnt (saturating at 16'hFFFF); match clears loss count; loss count reaching LOSS_THRESH -> SLIP next cycle, locked low, slip_cnt continues from current value.
REQ-023 word_valid in SLIP state SHALL be ignored (not counted toward WAIT).
REQ-024 enable low in any state -> IDLE next edge, overriding a simultaneous word_valid; clears match/loss/wait counts, slip_cnt, align_fail, locked; err_cnt retained.
REQ-025 bitslip SHALL never be high on two consecutive cycles; minimum spacing = SLIP_WAIT strobes.
REQ-026 Latency: word_valid completing lock -> locked high on the next rising edge.

Reset
REQ-027 reset SHALL force IDLE, bitslip=0, slip_cnt=0, locked=0, align_fail=0, err_cnt=0, all internal counts 0.
REQ-028 reset mid-operation SHALL abort any pending slip; no bitslip pulse after reset deassert until a new mismatch in CHECK.

Structure
REQ-029 State encoding type and parameter defaults SHALL live in shared package ewrapper_rx_pkg.
REQ-030 No sub-module required; comparator and counters inline.

Verification
REQ-031 enable=1, frame_byte=8'h3C on 16 strobes -> locked rises one cycle after 16th strobe, bitslip never pulses, slip_cnt=0.
REQ-032 frame_byte=8'h1E (rotated pattern) 3 strobes then 8'h3C -> exactly one bitslip per mismatch, 4 ignored strobes after each, lock after 16 matches, slip_cnt=1.
REQ-033 constant 8'h00 -> 8 bitslip pulses, align_fail set on 8th, slip_cnt=0, locked stays 0.
REQ-034 in LOCKED, 3 mismatches then match then 4 mismatches -> err_cnt=7, locked drops after 4th consecutive, bitslip pulses once.
REQ-035 enable deasserted coincident with word_valid in WAIT -> IDLE next cycle, no bitslip, align_fail cleared, err_cnt unchanged.
REQ-036 reset asserted during SLIP -> bitslip low immediately, all outputs zero.

Source files
------------

// File: rtl/ewrapper_rx_pkg.sv
// Shared state encoding, parameter defaults and helpers for the ewrapper
// receive-side frame alignment logic.
package ewrapper_rx_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CHECK  = 3'd1;
   localparam state_t ST_SLIP   = 3'd2;
   localparam state_t ST_WAIT   = 3'd3;
   localparam state_t ST_LOCKED = 3'd4;

   localparam logic [7:0] DEF_PATTERN      = 8'h3C;
   localparam int         DEF_MATCH_NEEDED = 32'd16;
   localparam int         DEF_LOSS_THRESH  = 32'd4;
   localparam int         DEF_SLIP_WAIT    = 32'd4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         sat_inc16 = value;
      end else begin
         sat_inc16 = value + 16'd1;
      end
   endfunction

endpackage

// File: rtl/ewrapper_rx_align_ctrl.sv
// Frame-lane word alignment: hunts for the training byte by bitslipping the
// deserializer, declares lock after a run of matches and monitors for loss.
module ewrapper_rx_align_ctrl
   import ewrapper_rx_pkg::*;
#(
   parameter logic [7:0] PATTERN      = DEF_PATTERN,
   parameter int         MATCH_NEEDED = DEF_MATCH_NEEDED,
   parameter int         LOSS_THRESH  = DEF_LOSS_THRESH,
   parameter int         SLIP_WAIT    = DEF_SLIP_WAIT
) (
   input  logic        rxi_lclk,
   input  logic        reset,
   input  logic        enable,
   input  logic        word_valid,
   input  logic [7:0]  frame_byte,
   output logic        bitslip,
   output logic [2:0]  slip_cnt,
   output logic        locked,
   output logic        align_fail,
   output logic [15:0] err_cnt
);

   // Counters compare against "last" values so the terminal word acts on the same edge.
   localparam logic [7:0] MATCH_LAST = 8'(MATCH_NEEDED - 32'd1);
   localparam logic [3:0] LOSS_LAST  = 4'(LOSS_THRESH - 32'd1);
   localparam logic [3:0] WAIT_LAST  = 4'(SLIP_WAIT - 32'd1);

   state_t      r_state;
   logic [7:0]  r_match_cnt;
   logic [3:0]  r_loss_cnt;
   logic [3:0]  r_wait_cnt;

   state_t      w_state;
   logic [7:0]  w_match_cnt;
   logic [3:0]  w_loss_cnt;
   logic [3:0]  w_wait_cnt;
   logic        w_bitslip;
   logic [2:0]  w_slip_cnt;
   logic        w_locked;
   logic        w_align_fail;
   logic [15:0] w_err_cnt;
   logic        w_is_match;
   logic        w_do_slip;

   assign w_is_match = (frame_byte == PATTERN);

   // Next-state and next-output decode for the alignment FSM.
   always_comb begin
      w_state      = r_state;
      w_match_cnt  = r_match_cnt;
      w_loss_cnt   = r_loss_cnt;
      w_wait_cnt   = r_wait_cnt;
      w_bitslip    = 1'b0;
      w_slip_cnt   = slip_cnt;
      w_locked     = locked;
      w_align_fail = align_fail;
      w_err_cnt    = err_cnt;
      w_do_slip    = 1'b0;
      if (!enable) begin
         w_state      = ST_IDLE;
         w_match_cnt  = 8'd0;
         w_loss_cnt   = 4'd0;
         w_wait_cnt   = 4'd0;
         w_slip_cnt   = 3'd0;
         w_locked     = 1'b0;
         w_align_fail = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state     = ST_CHECK;
               w_match_cnt = 8'd0;
               w_wait_cnt  = 4'd0;
            end
            ST_CHECK: begin
               if (word_valid && w_is_match) begin
                  if (r_match_cnt == MATCH_LAST) begin
                     w_state     = ST_LOCKED;
                     w_locked    = 1'b1;
                     w_match_cnt = 8'd0;
                     w_loss_cnt  = 4'd0;
                  end else begin
                     w_match_cnt = r_match_cnt + 8'd1;
                  end
               end else if (word_valid) begin
                  w_match_cnt = 8'd0;
                  w_do_slip   = 1'b1;
               end else begin
                  w_match_cnt = r_match_cnt;
               end
            end
            // Strobes landing in SLIP are deliberately dropped.
            ST_SLIP: begin
               w_state    = ST_WAIT;
               w_wait_cnt = 4'd0;
            end
            ST_WAIT: begin
               if (word_valid) begin
                  if (r_wait_cnt == WAIT_LAST) begin
                     w_state    = ST_CHECK;
                     w_wait_cnt = 4'd0;
                  end else begin
                     w_wait_cnt = r_wait_cnt + 4'd1;
                  end
               end else begin
                  w_wait_cnt = r_wait_cnt;
               end
            end
            ST_LOCKED: begin
               if (word_valid && w_is_match) begin
                  w_loss_cnt = 4'd0;
               end else if (word_valid) begin
                  w_err_cnt = sat_inc16(err_cnt);
                  if (r_loss_cnt == LOSS_LAST) begin
                     w_loss_cnt = 4'd0;
                     w_locked   = 1'b0;
                     w_do_slip  = 1'b1;
                  end else begin
                     w_loss_cnt = r_loss_cnt + 4'd1;
                  end
               end else begin
                  w_loss_cnt = r_loss_cnt;
               end
            end
            default: begin
               w_state = ST_IDLE;
            end
         endcase
         // A slip pulse coincides with the SLIP state; wrap of slip_cnt flags failure.
         if (w_do_slip) begin
            w_state    = ST_SLIP;
            w_bitslip  = 1'b1;
            w_slip_cnt = slip_cnt + 3'd1;
            if (slip_cnt == 3'd7) begin
               w_align_fail = 1'b1;
            end else begin
               w_align_fail = align_fail;
            end
         end else begin
            w_bitslip = 1'b0;
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge rxi_lclk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_match_cnt <= 8'd0;
         r_loss_cnt  <= 4'd0;
         r_wait_cnt  <= 4'd0;
         bitslip     <= 1'b0;
         slip_cnt    <= 3'd0;
         locked      <= 1'b0;
         align_fail  <= 1'b0;
         err_cnt     <= 16'd0;
      end else begin
         r_state     <= w_state;
         r_match_cnt <= w_match_cnt;
         r_loss_cnt  <= w_loss_cnt;
         r_wait_cnt  <= w_wait_cnt;
         bitslip     <= w_bitslip;
         slip_cnt    <= w_slip_cnt;
         locked      <= w_locked;
         align_fail  <= w_align_fail;
         err_cnt     <= w_err_cnt;
      end
   end

endmodule

// File: tb/tb_ewrapper_rx_align_ctrl.sv
// Randomized self-checking bench for ewrapper_rx_align_ctrl against an
// event-level model of the alignment rules.
module tb_ewrapper_rx_align_ctrl;

   localparam logic [7:0] PAT = 8'h3C;
   localparam int MN = 16;
   localparam int LT = 4;
   localparam int SW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        word_valid;
   logic [7:0]  frame_byte;
   logic        bitslip;
   logic [2:0]  slip_cnt;
   logic        locked;
   logic        align_fail;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulse  = 0;
   logic prev_slip = 1'b0;

   // Model: link-level view (searching / skipping strobes / locked)
   bit m_active, m_lock, m_slip, m_fail;
   int m_skip, m_good, m_bad, m_slips, m_errs;

   ewrapper_rx_align_ctrl #(
      .PATTERN(PAT), .MATCH_NEEDED(MN), .LOSS_THRESH(LT), .SLIP_WAIT(SW)
   ) dut (
      .rxi_lclk(clk), .reset(reset), .enable(enable), .word_valid(word_valid),
      .frame_byte(frame_byte), .bitslip(bitslip), .slip_cnt(slip_cnt),
      .locked(locked), .align_fail(align_fail), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_lock = 0; m_slip = 0; m_fail = 0;
      m_skip = 0; m_good = 0; m_bad = 0; m_slips = 0; m_errs = 0;
   endtask

   task automatic issue_slip();
      m_slip  = 1;
      m_slips = m_slips + 1;
      if (m_slips == 8) begin
         m_slips = 0;
         m_fail  = 1;
      end
   endtask

   task automatic model_edge(input logic en, input logic wv, input logic [7:0] b);
      if (!en) begin
         m_active = 0; m_lock = 0; m_slip = 0; m_fail = 0;
         m_skip = 0; m_good = 0; m_bad = 0; m_slips = 0;
         return;
      end
      if (!m_active) begin
         m_active = 1; m_good = 0; m_skip = 0;
         return;
      end
      if (m_slip) begin
         m_slip = 0;
         m_skip = SW;
         return;
      end
      if (!wv) return;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (m_lock) begin
         if (b == PAT) begin
            m_bad = 0;
         end else begin
            if (m_errs != 65535) m_errs++;
            m_bad++;
            if (m_bad == LT) begin
               m_lock = 0;
               m_bad  = 0;
               issue_slip();
            end
         end
      end else if (b == PAT) begin
         m_good++;
         if (m_good == MN) begin
            m_lock = 1; m_good = 0; m_bad = 0;
         end
      end else begin
         m_good = 0;
         issue_slip();
      end
   endtask

   task automatic compare_all();
      chk("bitslip", bitslip, m_slip);
      chk("slip_cnt", slip_cnt, m_slips);
      chk("locked", locked, m_lock);
      chk("align_fail", align_fail, m_fail);
      chk("err_cnt", err_cnt, m_errs);
      chk("slip_gap", bitslip & prev_slip, 1'b0);
      prev_slip = bitslip;
      if (bitslip) n_pulse++;
   endtask

   task automatic step(input logic en, input logic wv, input logic [7:0] b);
      enable = en; word_valid = wv; frame_byte = b;
      @(posedge clk);
      model_edge(en, wv, b);
      @(negedge clk);
      compare_all();
   endtask

   task automatic strobe(input logic en, input logic [7:0] b);
      step(en, 1'b1, b);
      repeat (3 + $urandom_range(0, 2)) step(en, 1'b0, 8'($urandom));
   endtask

   function automatic logic [7:0] bad_byte();
      logic [7:0] v;
      v = 8'($urandom);
      if (v == PAT) v = v ^ 8'h01;
      return v;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_bitslip"}, bitslip, 1'b0);
      chk({tag, "_slip_cnt"}, slip_cnt, 3'd0);
      chk({tag, "_locked"}, locked, 1'b0);
      chk({tag, "_align_fail"}, align_fail, 1'b0);
      chk({tag, "_err_cnt"}, err_cnt, 16'd0);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; word_valid = 1'b0; frame_byte = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // Clean pattern: lock one edge after the 16th strobe, no slips
      step(1'b1, 1'b0, 8'h00);
      n_pulse = 0;
      for (int i = 0; i < 15; i++) strobe(1'b1, PAT);
      chk("s1_pre_lock", locked, 1'b0);
      step(1'b1, 1'b1, PAT);
      chk("s1_lock", locked, 1'b1);
      chk("s1_pulses", n_pulse, 0);

      // Rotated pattern first: one slip, lock afterwards
      step(1'b0, 1'b0, 8'h00);
      n_pulse = 0;
      for (int i = 0; i < 3; i++) strobe(1'b1, 8'h1E);
      for (int i = 0; i < 20; i++) strobe(1'b1, PAT);
      chk("s2_pulses", n_pulse, 1);
      chk("s2_slip_cnt", slip_cnt, 3'd1);
      chk("s2_locked", locked, 1'b1);

      // Loss of lock: 3 bad, 1 good, 4 bad
      n_pulse = 0;
      for (int i = 0; i < 3; i++) strobe(1'b1, bad_byte());
      strobe(1'b1, PAT);
      for (int i = 0; i < 4; i++) strobe(1'b1, bad_byte());
      chk("s3_err_cnt", err_cnt, 16'd7);
      chk("s3_locked", locked, 1'b0);
      chk("s3_pulses", n_pulse, 1);

      // No alignment possible: 8 slips then align_fail
      step(1'b0, 1'b0, 8'h00);
      n_pulse = 0;
      for (int i = 0; i < 40; i++) strobe(1'b1, 8'h00);
      chk("s4_pulses", n_pulse, 8);
      chk("s4_align_fail", align_fail, 1'b1);
      chk("s4_slip_cnt", slip_cnt, 3'd0);
      chk("s4_locked", locked, 1'b0);

      // Enable dropped on a strobe while waiting after a slip
      strobe(1'b1, 8'h00);
      strobe(1'b1, 8'h00);
      n_pulse = 0;
      step(1'b0, 1'b1, 8'h00);
      chk("s5_bitslip", bitslip, 1'b0);
      chk("s5_align_fail", align_fail, 1'b0);
      chk("s5_err_cnt", err_cnt, 16'd7);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      chk("s5_pulses", n_pulse, 0);

      // Random traffic with mixed match density and enable drops
      for (int r = 0; r < 14; r++) begin
         int pct;
         pct = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 97 : int'($urandom_range(0, 100)));
         for (int k = 0; k < 30; k++) begin
            logic en;
            en = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < pct) strobe(en, PAT);
            else strobe(en, bad_byte());
         end
      end

      // Reset while a slip pulse is high
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h00);
      chk("s7_slip_before_reset", bitslip, 1'b1);
      reset = 1'b1;
      #1;
      check_zero("s7_reset");
      model_reset();
      enable = 1'b1; word_valid = 1'b1; frame_byte = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      prev_slip = 1'b0;
      n_pulse = 0;
      repeat (10) step(1'b1, 1'b0, 8'h00);
      chk("s7_no_pulse", n_pulse, 0);
      for (int i = 0; i < 18; i++) strobe(1'b1, PAT);
      chk("s7_relock", locked, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
